tty_write_arbiter: RTL and testbench

- Shares the single write port of the tty buffer (WE / WRITE_ADDR / DATA_IN) between two requesters: A = CPU bus bridge, B = debug/status writer.
- Arbitration is round-robin. Outputs are registered and the protocol is a req/ack handshake.
- Detects the end-of-test write (address DONE_ADDR, data DONE_DATA). It then raises a sticky done flag and blocks all further writes, so benches and top-level logic have one termination signal.
- Keeps a saturating count of issued writes.

---
 rtl/tty_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_tty_write_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tty_write_arbiter.sv
// -----------------------------------------------------------------------------
// tty_write_arbiter
//
// Purpose:
//   Lets two requesters share the single write port of the tty buffer.
//   A is the CPU bus bridge and B is the debug/status writer. The two are
//   served round-robin over a req/ack handshake, and all outputs are
//   registered. The block recognises the end-of-test write
//   (DONE_ADDR / DONE_DATA) and then raises a sticky done flag, after which
//   no further writes are issued. It also keeps a saturating count of
//   issued writes.
//
// Ports:
//   clock            system clock, all logic on posedge
//   reset            synchronous, active-high reset
//   a_req/a_addr/a_data   requester A write; held stable until a_ack
//   a_ack            one-cycle pulse: A's write issued this cycle
//   b_req/b_addr/b_data   requester B write; held stable until b_ack
//   b_ack            one-cycle pulse: B's write issued this cycle
//   tty_we           tty buffer write enable (WE)
//   tty_addr         tty buffer write address (WRITE_ADDR)
//   tty_data         tty buffer write data (DATA_IN)
//   done             sticky end-of-test flag, cleared only by reset
//   wr_count         writes issued since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module tty_write_arbiter #(
    parameter int                 ADDR_W    = 10,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  DONE_ADDR = 10'h000,
    parameter logic [DATA_W-1:0]  DONE_DATA = 32'h0000_00FF,
    parameter int                 CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,
    output logic              tty_we,
    output logic [ADDR_W-1:0] tty_addr,
    output logic [DATA_W-1:0] tty_data,
    output logic              done,
    output logic [CNT_W-1:0]  wr_count
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    logic              tty_we_q,   tty_we_d;
    logic [ADDR_W-1:0] tty_addr_q, tty_addr_d;
    logic [DATA_W-1:0] tty_data_q, tty_data_d;
    logic              a_ack_q,    a_ack_d;
    logic              b_ack_q,    b_ack_d;
    logic              done_q,     done_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    grant_e            last_grant_q, last_grant_d;

    logic              a_elig;
    logic              b_elig;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        tty_we_d     = 1'b0;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        tty_addr_d   = tty_addr_q;
        tty_data_d   = tty_data_q;
        done_d       = done_q;
        wr_count_d   = wr_count_q;
        last_grant_d = last_grant_q;

        // A request whose ack is still high has already been issued and
        // not yet retired by its owner; serving it again would duplicate it.
        a_elig = a_req && !a_ack_q && !done_q;
        b_elig = b_req && !b_ack_q && !done_q;

        // On a tie, the requester that was not served last wins.
        grant_a = a_elig && (!b_elig || (last_grant_q == GRANT_B));
        grant_b = b_elig && (!a_elig || (last_grant_q == GRANT_A));

        sel_addr = grant_a ? a_addr : b_addr;
        sel_data = grant_a ? a_data : b_data;

        if (grant_a || grant_b) begin
            tty_we_d     = 1'b1;
            tty_addr_d   = sel_addr;
            tty_data_d   = sel_data;
            a_ack_d      = grant_a;
            b_ack_d      = grant_b;
            last_grant_d = grant_a ? GRANT_A : GRANT_B;

            if (wr_count_q != {CNT_W{1'b1}}) begin
                wr_count_d = wr_count_q + CNT_W'(1);
            end

            // The done write itself still goes out; done rises with it.
            if ((sel_addr == DONE_ADDR) && (sel_data == DONE_DATA)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tty_we_q     <= 1'b0;
            tty_addr_q   <= '0;
            tty_data_q   <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            done_q       <= 1'b0;
            wr_count_q   <= '0;
            last_grant_q <= GRANT_B;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, so ordering inside this block does not matter.
            tty_we_q     <= tty_we_d;
            tty_addr_q   <= tty_addr_d;
            tty_data_q   <= tty_data_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            done_q       <= done_d;
            wr_count_q   <= wr_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign tty_we   = tty_we_q;
    assign tty_addr = tty_addr_q;
    assign tty_data = tty_data_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_tty_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tty_write_arbiter
//
// Directed bench for tty_write_arbiter. The stimulus process drives
// requests and pushes the expected write (requester, address, data, done)
// into a queue. A monitor on the falling edge pops an entry for every
// tty_we pulse and compares it. The stimulus also checks cycle-level state
// directly: idle cycles, counter values, done, and stalls.
// -----------------------------------------------------------------------------
module tb_tty_write_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef struct {
        logic              is_a;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              done;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ack;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ack;
    logic              tty_we;
    logic [ADDR_W-1:0] tty_addr;
    logic [DATA_W-1:0] tty_data;
    logic              done;
    logic [CNT_W-1:0]  wr_count;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en  = 1'b0;
    bit   bulk    = 1'b0;
    exp_t exp_q[$];

    tty_write_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ack    (a_ack),
        .b_req    (b_req),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ack    (b_ack),
        .tty_we   (tty_we),
        .tty_addr (tty_addr),
        .tty_data (tty_data),
        .done     (done),
        .wr_count (wr_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance one clock; inputs change 2 time units after the edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic is_a, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic dn);
        exp_t e;
        e.is_a = is_a;
        e.addr = addr;
        e.data = data;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every issued write must match the queue head.
    always @(negedge clock) begin
        if (mon_en && !bulk) begin
            if (tty_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h a_ack=%0b b_ack=%0b, wanted no write (t=%0t)",
                             tty_addr, tty_data, a_ack, b_ack, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(tty_addr), 64'(e.addr));
                    check("wr_data", 64'(tty_data), 64'(e.data));
                    check("wr_acks", 64'({a_ack, b_ack}), 64'({e.is_a, !e.is_a}));
                    check("wr_done", 64'(done), 64'(e.done));
                end
            end else begin
                check("idle_acks", 64'({tty_we, a_ack, b_ack}), 64'(0));
            end
        end
    end

    initial begin
        reset  = 1'b1;
        a_req  = 1'b0;
        a_addr = '0;
        a_data = '0;
        b_req  = 1'b0;
        b_addr = '0;
        b_data = '0;

        // ---- reset then idle ----
        repeat (3) step();
        mon_en = 1'b1;
        check("rst_we",    64'(tty_we),   64'(0));
        check("rst_addr",  64'(tty_addr), 64'(0));
        check("rst_data",  64'(tty_data), 64'(0));
        check("rst_done",  64'(done),     64'(0));
        check("rst_count", 64'(wr_count), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_we",    64'(tty_we),   64'(0));
            check("idle_done",  64'(done),     64'(0));
            check("idle_count", 64'(wr_count), 64'(0));
        end

        // ---- single A write ----
        a_req = 1'b1; a_addr = 10'h005; a_data = 32'h41;
        push(1'b1, 10'h005, 32'h41, 1'b0);
        step();
        check("single_we",  64'(tty_we), 64'(1));
        check("single_ack", 64'(a_ack),  64'(1));
        a_req = 1'b0;
        step();
        check("single_we_off", 64'(tty_we),   64'(0));
        check("single_count",  64'(wr_count), 64'(1));

        // ---- simultaneous requests: A first after reset, then alternate ----
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_req = 1'b1; a_addr = 10'h001; a_data = 32'h11;
        b_req = 1'b1; b_addr = 10'h002; b_data = 32'h22;
        push(1'b1, 10'h001, 32'h11, 1'b0);
        push(1'b0, 10'h002, 32'h22, 1'b0);
        push(1'b1, 10'h001, 32'h13, 1'b0);
        push(1'b0, 10'h002, 32'h24, 1'b0);
        push(1'b1, 10'h001, 32'h15, 1'b0);
        push(1'b0, 10'h002, 32'h26, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("alt_we",    64'(tty_we),   64'(1));
            check("alt_count", 64'(wr_count), 64'(k));
            // The requester just acked presents its next write, or retires.
            if (k % 2 == 1) begin
                if (k == 5) a_req = 1'b0;
                else        a_data = a_data + 32'h2;
            end else begin
                if (k == 6) b_req = 1'b0;
                else        b_data = b_data + 32'h2;
            end
        end
        step();
        check("alt_we_off", 64'(tty_we),   64'(0));
        check("alt_count6", 64'(wr_count), 64'(6));

        // ---- ack exclusion: A never retires, writes every other cycle ----
        a_req = 1'b1; a_addr = 10'h007; a_data = 32'h77;
        repeat (4) push(1'b1, 10'h007, 32'h77, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("excl_we", 64'(tty_we), 64'(k % 2));
        end
        a_req = 1'b0;
        step();
        check("excl_count", 64'(wr_count), 64'(10));

        // ---- near misses: done address with wrong data, and the reverse ----
        b_req = 1'b1; b_addr = 10'h000; b_data = 32'hFE;
        push(1'b0, 10'h000, 32'hFE, 1'b0);
        step();
        b_req = 1'b0;
        step();
        check("miss_data_done", 64'(done), 64'(0));
        a_req = 1'b1; a_addr = 10'h001; a_data = 32'hFF;
        push(1'b1, 10'h001, 32'hFF, 1'b0);
        step();
        a_req = 1'b0;
        step();
        check("miss_addr_done", 64'(done),     64'(0));
        check("miss_count",     64'(wr_count), 64'(12));

        // ---- done write from B, then A stalls ----
        b_req = 1'b1; b_addr = 10'h000; b_data = 32'hFF;
        push(1'b0, 10'h000, 32'hFF, 1'b1);
        step();
        check("done_same_cycle", 64'({done, tty_we}), 64'(2'b11));
        b_req = 1'b0;
        a_req = 1'b1; a_addr = 10'h003; a_data = 32'h33;
        for (int k = 0; k < 6; k++) begin
            step();
            check("stall_we",   64'(tty_we), 64'(0));
            check("stall_ack",  64'(a_ack),  64'(0));
            check("stall_done", 64'(done),   64'(1));
        end
        check("stall_count", 64'(wr_count), 64'(13));

        // ---- reset pulse with A still requesting: nothing written in reset ----
        reset = 1'b1;
        step();
        check("rst2_done",  64'(done),     64'(0));
        check("rst2_count", 64'(wr_count), 64'(0));
        check("rst2_we",    64'(tty_we),   64'(0));
        reset = 1'b0;
        push(1'b1, 10'h003, 32'h33, 1'b0);
        step();
        check("post_rst_we",    64'(tty_we),   64'(1));
        check("post_rst_count", 64'(wr_count), 64'(1));
        a_req = 1'b0;
        step();

        // ---- saturation: both requesters held, one write per cycle ----
        reset = 1'b1;
        step();
        reset = 1'b0;
        bulk  = 1'b1;
        a_req = 1'b1; a_addr = 10'h010; a_data = 32'h1;
        b_req = 1'b1; b_addr = 10'h011; b_data = 32'h2;
        repeat (65534) step();
        check("sat_pre",  64'(wr_count), 64'(16'hFFFE));
        step();
        check("sat_hit",  64'(wr_count), 64'(16'hFFFF));
        repeat (5) step();
        check("sat_hold", 64'(wr_count), 64'(16'hFFFF));
        check("sat_we",   64'(tty_we),   64'(1));
        check("sat_done", 64'(done),     64'(0));
        a_req = 1'b0;
        b_req = 1'b0;
        step();
        step();
        bulk = 1'b0;

        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
